run_monitor: RTL and testbench
==============================

// Module: run_monitor
// PURPOSE
//  Synthesizable run-control monitor for the processor cores. Watches the fetched
//  instruction and PC each cycle and tracks a program run from start to its end.
//  A run ends on a halt trap (pass), a PC hang (fail) or a cycle timeout (fail).
//  Sits beside singlecycle or a later multicycle/pipelined core. Replaces bench-side
//  trap polling and #delay finishes with counters and status the bench reads directly.
// PARAMETERS
//  PC_W        32            PC width
//  INSTR_W     32            instruction width
//  CNT_W       32            cycle/retire counter width
//  TRAP_CODE   32'h44000300  instruction word that ends a run successfully
//  MAX_CYCLES  2500          RUN cycles before TIMEOUT; 0 disables timeout
//  HANG_LIMIT  16            consecutive valid instrs at same PC -> HUNG; 0 disables
// PORTS
//  clock        in   1        core clock
//  reset        in   1        asynchronous, active-high
//  start        in   1        1-cycle pulse: begin a run
//  instr_valid  in   1        instr/pc describe an instruction retiring this cycle
//  instr        in   INSTR_W  instruction word
//  pc           in   PC_W     PC of instr
//  running      out  1        state == RUN
//  done         out  1        state is HALTED, HUNG or TIMEOUT
//  pass         out  1        state == HALTED
//  status       out  2        0 IDLE/RUN, 1 HALTED, 2 HUNG, 3 TIMEOUT
//  cycle_count  out  CNT_W    clock cycles spent in RUN, saturating
//  retired      out  CNT_W    valid instructions seen in RUN (incl. trap), saturating
//  last_pc      out  PC_W     PC of most recent valid instruction
// BEHAVIOUR
//  - Reset (async, any state, mid-run included): state IDLE; all outputs 0; hang counter 0.
//  - States: IDLE, RUN, HALTED, HUNG, TIMEOUT. Outputs are registered and change at the
//    clock edge of the transition.
//  - Transitions:
//    - IDLE --start--> RUN. Counters and last_pc clear on that edge.
//    - Terminal --start--> RUN, same clears; re-arm needs no reset.
//    - start while in RUN: ignored.
//  - RUN, every edge: cycle_count += 1.
//  - RUN, on instr_valid: retired += 1; last_pc <= pc.
//  - Hang: in RUN with instr_valid, same_cnt is 0 for the first valid instr of a run.
//    Otherwise same_cnt += 1 if pc == last_pc, else same_cnt <= 0.
//  - End conditions, evaluated in RUN on the current edge:
//    - trap: instr_valid && instr == TRAP_CODE
//    - hang: HANG_LIMIT != 0 && next same_cnt == HANG_LIMIT
//    - tout: MAX_CYCLES != 0 && next cycle_count == MAX_CYCLES
//  - Simultaneous end conditions: priority trap > hang > timeout.
//  - Counters still update on the terminating edge, then freeze in terminal states.
//  - instr_valid=0: no retire, no hang update, timeout still advances.
//  - Saturation at 2^CNT_W-1: counters hold, no wrap. Timeout compare uses the
//    saturated value.
//  - Latency: a trap on edge N gives done=pass=1, status=1 after edge N. No combinational
//    path from inputs to outputs.
// STRUCTURE
//  - Shared package run_pkg:
//    - state enum {IDLE, RUN, HALTED, HUNG, TIMEOUT}
//    - status encodings
//    - default TRAP_CODE constant, so benches and cores share one definition
//  - Sub-module sat_counter #(W):
//    - ports: clock, reset, clr, inc, q
//    - saturating up-counter, instantiated for cycle_count, retired and same_cnt
// TESTING
//  1. Reset then start; 5 valid instrs at pc 0,4,8,12,16, the last = 32'h44000300
//     -> done=1, pass=1, status=1, retired=5, cycle_count=5, last_pc=16.
//  2. MAX_CYCLES=10, no trap, PCs incrementing -> status=3 exactly after the 10th RUN edge,
//     cycle_count=10, pass=0.
//  3. HANG_LIMIT=4, pc held at 0x20 with valid=1 -> status=2 after the 5th valid instr
//     (4 repeats), last_pc=0x20.
//  4. Trap at a repeated PC on the same edge hang hits, and MAX_CYCLES also reached
//     -> status=1 (trap wins).
//  5. Reset asserted mid-run after 7 cycles, asynchronously between edges -> outputs 0
//     immediately, state IDLE. A later start runs from zero counts.
//  6. After HALTED, pulse start; start again while running; toggle instr_valid 0/1
//     -> second start ignored; counters restarted at 0; retired counts only valid cycles.

Source files
------------

// File: rtl/run_pkg.sv
// Shared definitions for the run-control monitor: state encoding, status codes
// and the halt-trap instruction word used by cores and benches alike.
package run_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_HALTED,
      S_HUNG,
      S_TIMEOUT
   } run_state_t;

   localparam logic [1:0] STATUS_IDLE_RUN = 2'd0;
   localparam logic [1:0] STATUS_HALTED   = 2'd1;
   localparam logic [1:0] STATUS_HUNG     = 2'd2;
   localparam logic [1:0] STATUS_TIMEOUT  = 2'd3;

   localparam logic [31:0] TRAP_CODE_DEFAULT = 32'h44000300;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   // Clear wins over increment so a restart on the same edge always starts from zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/run_monitor.sv
// Run-control monitor: follows a program run from start until it halts on the
// trap word, hangs on one PC, or exceeds its cycle budget.
module run_monitor
   import run_pkg::*;
#(
   parameter int                PC_W       = 32,
   parameter int                INSTR_W    = 32,
   parameter int                CNT_W      = 32,
   parameter logic [INSTR_W-1:0] TRAP_CODE = INSTR_W'(TRAP_CODE_DEFAULT),
   parameter int                MAX_CYCLES = 2500,
   parameter int                HANG_LIMIT = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   input  logic [PC_W-1:0]    pc,
   output logic               running,
   output logic               done,
   output logic               pass,
   output logic [1:0]         status,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [CNT_W-1:0]   retired,
   output logic [PC_W-1:0]    last_pc
);

   run_state_t       state_q;
   logic             seen_valid;
   logic [CNT_W-1:0] same_cnt;

   logic             arm;
   logic             in_run;
   logic             same_pc;
   logic [CNT_W-1:0] cyc_next;
   logic [CNT_W-1:0] same_next;
   logic             trap_hit;
   logic             hang_hit;
   logic             tout_hit;
   logic             same_clr;
   logic             same_inc;

   // End conditions look at the values the counters will hold after this edge,
   // so a run stops on exactly the edge its limit is reached.
   always_comb begin
      arm       = start && (state_q != S_RUN);
      in_run    = (state_q == S_RUN);
      same_pc   = seen_valid && (pc == last_pc);
      cyc_next  = (cycle_count == {CNT_W{1'b1}}) ? cycle_count : cycle_count + CNT_W'(1);
      same_next = '0;
      if (same_pc) begin
         same_next = (same_cnt == {CNT_W{1'b1}}) ? same_cnt : same_cnt + CNT_W'(1);
      end
      trap_hit = in_run && instr_valid && (instr == TRAP_CODE);
      hang_hit = in_run && instr_valid && (HANG_LIMIT != 0) && (same_next == CNT_W'(HANG_LIMIT));
      tout_hit = in_run && (MAX_CYCLES != 0) && (cyc_next == CNT_W'(MAX_CYCLES));
      same_clr = arm || (in_run && instr_valid && !same_pc);
      same_inc = in_run && instr_valid && same_pc;
   end

   sat_counter #(.W(CNT_W)) u_cycle (
      .clock (clock),
      .reset (reset),
      .clr   (arm),
      .inc   (in_run),
      .q     (cycle_count)
   );

   sat_counter #(.W(CNT_W)) u_retired (
      .clock (clock),
      .reset (reset),
      .clr   (arm),
      .inc   (in_run && instr_valid),
      .q     (retired)
   );

   sat_counter #(.W(CNT_W)) u_same (
      .clock (clock),
      .reset (reset),
      .clr   (same_clr),
      .inc   (same_inc),
      .q     (same_cnt)
   );

   // Flags are registered alongside the state so they move on the transition edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         seen_valid <= 1'b0;
         last_pc    <= '0;
         running    <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         status     <= STATUS_IDLE_RUN;
      end else if (arm) begin
         state_q    <= S_RUN;
         seen_valid <= 1'b0;
         last_pc    <= '0;
         running    <= 1'b1;
         done       <= 1'b0;
         pass       <= 1'b0;
         status     <= STATUS_IDLE_RUN;
      end else if (in_run) begin
         if (instr_valid) begin
            seen_valid <= 1'b1;
            last_pc    <= pc;
         end
         if (trap_hit) begin
            state_q <= S_HALTED;
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
            status  <= STATUS_HALTED;
         end else if (hang_hit) begin
            state_q <= S_HUNG;
            running <= 1'b0;
            done    <= 1'b1;
            status  <= STATUS_HUNG;
         end else if (tout_hit) begin
            state_q <= S_TIMEOUT;
            running <= 1'b0;
            done    <= 1'b1;
            status  <= STATUS_TIMEOUT;
         end
      end
   end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: a small-limit instance plus a narrow-counter
// instance with both limits disabled, sharing one stimulus stream.
module tb_run_monitor;
   import run_pkg::*;

   localparam logic [31:0] NOP  = 32'h00000013;
   localparam logic [31:0] TRAP = 32'h44000300;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;

   logic        running, done, pass;
   logic [1:0]  status;
   logic [31:0] cycle_count, retired, last_pc;

   logic        s_running, s_done, s_pass;
   logic [1:0]  s_status;
   logic [2:0]  s_cycle_count, s_retired;
   logic [31:0] s_last_pc;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   run_monitor #(.MAX_CYCLES(10), .HANG_LIMIT(4)) dut (
      .clock(clock), .reset(reset), .start(start), .instr_valid(instr_valid),
      .instr(instr), .pc(pc), .running(running), .done(done), .pass(pass),
      .status(status), .cycle_count(cycle_count), .retired(retired), .last_pc(last_pc)
   );

   run_monitor #(.CNT_W(3), .MAX_CYCLES(0), .HANG_LIMIT(0)) dut_sat (
      .clock(clock), .reset(reset), .start(start), .instr_valid(instr_valid),
      .instr(instr), .pc(pc), .running(s_running), .done(s_done), .pass(s_pass),
      .status(s_status), .cycle_count(s_cycle_count), .retired(s_retired), .last_pc(s_last_pc)
   );

   // Inputs change 1 time unit after each rising edge; outputs are read at the same point.
   task automatic step(input logic st, input logic v, input logic [31:0] i, input logic [31:0] p);
      start = st; instr_valid = v; instr = i; pc = p;
      @(posedge clock); #1;
      start = 1'b0; instr_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; instr_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      reset = 1'b1; #1;
      vectors++;
      if ({running, done, pass, status} !== 5'b0) begin
         miscompares++; $display("[TB] FAIL reset_flags: got %b want 00000", {running, done, pass, status});
      end
      vectors++;
      if ({cycle_count, retired, last_pc} !== 96'b0) begin
         miscompares++; $display("[TB] FAIL reset_counts: got %0d/%0d/%h want 0/0/0", cycle_count, retired, last_pc);
      end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_trap_pass();
      do_reset();
      step(1'b1, 1'b0, NOP, 32'd0);
      vectors++;
      if (running !== 1'b1 || cycle_count !== 32'd0) begin
         miscompares++; $display("[TB] FAIL trap_armed: got running=%b cyc=%0d want 1/0", running, cycle_count);
      end
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, NOP, 32'(4 * k));
      vectors++;
      if (done !== 1'b0 || status !== 2'd0) begin
         miscompares++; $display("[TB] FAIL trap_early: got done=%b status=%0d want 0/0", done, status);
      end
      step(1'b0, 1'b1, TRAP, 32'd16);
      vectors++;
      if ({running, done, pass, status} !== 5'b01101) begin
         miscompares++; $display("[TB] FAIL trap_flags: got %b want 01101", {running, done, pass, status});
      end
      vectors++;
      if (retired !== 32'd5 || cycle_count !== 32'd5 || last_pc !== 32'd16) begin
         miscompares++; $display("[TB] FAIL trap_counts: got %0d/%0d/%0d want 5/5/16", retired, cycle_count, last_pc);
      end
      vectors++;
      if (s_status !== 2'd1 || s_cycle_count !== 3'd5 || s_retired !== 3'd5) begin
         miscompares++; $display("[TB] FAIL trap_narrow: got %0d/%0d/%0d want 1/5/5", s_status, s_cycle_count, s_retired);
      end
      step(1'b0, 1'b1, NOP, 32'd20);
      vectors++;
      if (cycle_count !== 32'd5 || retired !== 32'd5 || last_pc !== 32'd16 || status !== 2'd1) begin
         miscompares++; $display("[TB] FAIL trap_frozen: got %0d/%0d/%0d/%0d want 5/5/16/1", cycle_count, retired, last_pc, status);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      step(1'b1, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 9; k++) step(1'b0, 1'b1, NOP, 32'(4 * k));
      vectors++;
      if (status !== 2'd0 || running !== 1'b1) begin
         miscompares++; $display("[TB] FAIL tout_early: got status=%0d running=%b want 0/1", status, running);
      end
      step(1'b0, 1'b1, NOP, 32'd36);
      vectors++;
      if ({running, done, pass, status} !== 5'b01011 || cycle_count !== 32'd10) begin
         miscompares++; $display("[TB] FAIL tout_flags: got %b cyc=%0d want 01011 cyc=10", {running, done, pass, status}, cycle_count);
      end
      vectors++;
      if (retired !== 32'd10 || last_pc !== 32'd36) begin
         miscompares++; $display("[TB] FAIL tout_counts: got %0d/%0d want 10/36", retired, last_pc);
      end
      step(1'b0, 1'b0, NOP, 32'd40);
      step(1'b0, 1'b1, NOP, 32'd44);
      vectors++;
      if (s_cycle_count !== 3'd7 || s_retired !== 3'd7 || s_status !== 2'd0 || s_running !== 1'b1) begin
         miscompares++; $display("[TB] FAIL sat_hold: got %0d/%0d/%0d/%b want 7/7/0/1", s_cycle_count, s_retired, s_status, s_running);
      end
      vectors++;
      if (s_last_pc !== 32'd44) begin
         miscompares++; $display("[TB] FAIL sat_last_pc: got %h want 0000002c", s_last_pc);
      end
   endtask

   task automatic test_hang();
      do_reset();
      step(1'b1, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, NOP, 32'h20);
      vectors++;
      if (status !== 2'd0 || done !== 1'b0) begin
         miscompares++; $display("[TB] FAIL hang_early: got status=%0d done=%b want 0/0", status, done);
      end
      step(1'b0, 1'b1, NOP, 32'h20);
      vectors++;
      if ({running, done, pass, status} !== 5'b01010 || last_pc !== 32'h20) begin
         miscompares++; $display("[TB] FAIL hang_flags: got %b pc=%h want 01010 pc=20", {running, done, pass, status}, last_pc);
      end
      vectors++;
      if (retired !== 32'd5 || cycle_count !== 32'd5 || s_status !== 2'd0) begin
         miscompares++; $display("[TB] FAIL hang_counts: got %0d/%0d narrow=%0d want 5/5/0", retired, cycle_count, s_status);
      end
   endtask

   task automatic test_priority();
      do_reset();
      step(1'b1, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, NOP, 32'h40);
      vectors++;
      if (status !== 2'd0 || cycle_count !== 32'd9) begin
         miscompares++; $display("[TB] FAIL prio_early: got status=%0d cyc=%0d want 0/9", status, cycle_count);
      end
      step(1'b0, 1'b1, TRAP, 32'h40);
      vectors++;
      if (status !== 2'd1 || pass !== 1'b1) begin
         miscompares++; $display("[TB] FAIL prio_trap: got status=%0d pass=%b want 1/1", status, pass);
      end
      do_reset();
      step(1'b1, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, NOP, 32'h40);
      vectors++;
      if (status !== 2'd2 || cycle_count !== 32'd10) begin
         miscompares++; $display("[TB] FAIL prio_hang: got status=%0d cyc=%0d want 2/10", status, cycle_count);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b1, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b1, NOP, 32'(4 * k));
      vectors++;
      if (cycle_count !== 32'd7 || running !== 1'b1 || last_pc !== 32'd24) begin
         miscompares++; $display("[TB] FAIL areset_pre: got %0d/%b/%0d want 7/1/24", cycle_count, running, last_pc);
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({running, done, pass, status} !== 5'b0 || {cycle_count, retired, last_pc} !== 96'b0) begin
         miscompares++; $display("[TB] FAIL areset_now: got flags=%b cyc=%0d ret=%0d pc=%h want all 0", {running, done, pass, status}, cycle_count, retired, last_pc);
      end
      #1 reset = 1'b0;
      step(1'b0, 1'b1, NOP, 32'd28);
      vectors++;
      if (running !== 1'b0 || cycle_count !== 32'd0 || retired !== 32'd0) begin
         miscompares++; $display("[TB] FAIL areset_idle: got %b/%0d/%0d want 0/0/0", running, cycle_count, retired);
      end
      step(1'b1, 1'b0, NOP, 32'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, NOP, 32'(32'h100 + 4 * k));
      vectors++;
      if (cycle_count !== 32'd3 || retired !== 32'd3 || last_pc !== 32'h108) begin
         miscompares++; $display("[TB] FAIL areset_rerun: got %0d/%0d/%h want 3/3/108", cycle_count, retired, last_pc);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(1'b1, 1'b0, NOP, 32'd0);
      step(1'b0, 1'b1, NOP, 32'd0);
      step(1'b0, 1'b1, TRAP, 32'd4);
      vectors++;
      if (status !== 2'd1 || cycle_count !== 32'd2) begin
         miscompares++; $display("[TB] FAIL b2b_halt: got status=%0d cyc=%0d want 1/2", status, cycle_count);
      end
      step(1'b1, 1'b0, NOP, 32'd0);
      vectors++;
      if ({running, done, pass, status} !== 5'b10000 || {cycle_count, retired, last_pc} !== 96'b0) begin
         miscompares++; $display("[TB] FAIL b2b_rearm: got flags=%b cyc=%0d ret=%0d pc=%h want 10000 0/0/0", {running, done, pass, status}, cycle_count, retired, last_pc);
      end
      step(1'b1, 1'b1, NOP, 32'h100);
      step(1'b0, 1'b0, NOP, 32'h200);
      step(1'b0, 1'b1, NOP, 32'h104);
      step(1'b0, 1'b0, NOP, 32'h300);
      vectors++;
      if (cycle_count !== 32'd4 || retired !== 32'd2 || last_pc !== 32'h104 || running !== 1'b1) begin
         miscompares++; $display("[TB] FAIL b2b_counts: got %0d/%0d/%h/%b want 4/2/104/1", cycle_count, retired, last_pc, running);
      end
      vectors++;
      if (s_cycle_count !== 3'd4 || s_retired !== 3'd2) begin
         miscompares++; $display("[TB] FAIL b2b_narrow: got %0d/%0d want 4/2", s_cycle_count, s_retired);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_trap_pass();
      test_timeout();
      test_hang();
      test_priority();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
